// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control path.
// Contents: the main FSM state encoding (4 bits), the RV32I opcode
// constants the sequencer decodes, and the encodings of the ALU/mux
// select buses (alu_op, alu_src_a, alu_src_b, result_src).
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

endpackage

// File: rtl/multicycle_control_fsm.sv
// Main control sequencer of the multi-cycle RV32I core (Moore FSM).
// Walks each instruction through fetch/decode/execute/memory/writeback and
// drives mux selects and write enables around the shared ALU, IR, PC and
// register file.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   op[OPCODE_W-1:0]    opcode field from the IR (sampled in DECODE/MEMADR)
//   mem_ready           memory access completes this cycle
//   alu_src_a/b, alu_op, result_src, adr_src   datapath selects
//   ir_write, pc_update, branch, reg_write, mem_write   write enables
//   illegal_op          one-cycle pulse on an unknown opcode in DECODE
// Optional (macro MULTICYCLE_CONTROL_FSM_DEBUG_UART_EN):
//   tx_Data[7:0], tx_DataValid  registered trace of the state that
//   handed control back to FETCH.
module multicycle_control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] op,
  input  logic                mem_ready,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          result_src,
  output logic                adr_src,
  output logic                ir_write,
  output logic                pc_update,
  output logic                branch,
  output logic                reg_write,
  output logic                mem_write,
  output logic                illegal_op
`ifdef MULTICYCLE_CONTROL_FSM_DEBUG_UART_EN
  ,
  output logic [7:0]          tx_Data,
  output logic                tx_DataValid
`endif
);

  state_t state, state_next;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH:    state_next = mem_ready ? DECODE : FETCH;
      DECODE: begin
        if (op == OP_LOAD || op == OP_STORE) state_next = MEMADR;
        else if (op == OP_RTYPE)             state_next = EXECR;
        else if (op == OP_ITYPE)             state_next = EXECI;
        else if (op == OP_JAL)               state_next = JAL;
        else if (op == OP_BEQ)               state_next = BEQ;
        else                                 state_next = FETCH;
      end
      // Only loads and stores reach MEMADR, so anything but lw is a store.
      MEMADR:   state_next = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
      MEMREAD:  state_next = mem_ready ? MEMWB : MEMREAD;
      MEMWB:    state_next = FETCH;
      MEMWRITE: state_next = mem_ready ? FETCH : MEMWRITE;
      EXECR:    state_next = ALUWB;
      EXECI:    state_next = ALUWB;
      ALUWB:    state_next = FETCH;
      JAL:      state_next = ALUWB;
      BEQ:      state_next = FETCH;
      default:  state_next = FETCH;
    endcase
  end

  // Outputs decode the current state; reset masks all of them so no write
  // enable can fire in the cycle an instruction is abandoned.
  always_comb begin
    alu_src_a  = '0;
    alu_src_b  = '0;
    alu_op     = '0;
    result_src = '0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    illegal_op = 1'b0;
    if (!reset) begin
      case (state)
        FETCH: begin
          adr_src    = 1'b0;
          alu_src_a  = SRCA_PC;
          alu_src_b  = SRCB_FOUR;
          alu_op     = ALU_ADD;
          result_src = RES_ALURES;
          ir_write   = mem_ready;
          pc_update  = mem_ready;
        end
        DECODE: begin
          alu_src_a  = SRCA_OLDPC;
          alu_src_b  = SRCB_IMM;
          alu_op     = ALU_ADD;
          illegal_op = !(op == OP_LOAD || op == OP_STORE || op == OP_RTYPE ||
                         op == OP_ITYPE || op == OP_JAL || op == OP_BEQ);
        end
        MEMADR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALU_ADD;
        end
        MEMREAD: begin
          adr_src    = 1'b1;
          result_src = RES_ALUOUT;
        end
        MEMWB: begin
          result_src = RES_RDATA;
          reg_write  = 1'b1;
        end
        MEMWRITE: begin
          adr_src    = 1'b1;
          result_src = RES_ALUOUT;
          mem_write  = 1'b1;
        end
        EXECR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_RS2;
          alu_op    = ALU_FUNCT;
        end
        EXECI: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALU_FUNCT;
        end
        ALUWB: begin
          result_src = RES_ALUOUT;
          reg_write  = 1'b1;
        end
        JAL: begin
          alu_src_a  = SRCA_OLDPC;
          alu_src_b  = SRCB_FOUR;
          alu_op     = ALU_ADD;
          result_src = RES_ALUOUT;
          pc_update  = 1'b1;
        end
        BEQ: begin
          alu_src_a  = SRCA_RS1;
          alu_src_b  = SRCB_RS2;
          alu_op     = ALU_SUB;
          result_src = RES_ALUOUT;
          branch     = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MULTICYCLE_CONTROL_FSM_DEBUG_UART_EN
  // Trace the state that returns control to FETCH; staying in FETCH and
  // reset-forced entries are not transitions worth reporting.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_Data      <= '0;
      tx_DataValid <= 1'b0;
    end else if (state_next == FETCH && state != FETCH) begin
      tx_Data      <= {4'h0, state};
      tx_DataValid <= 1'b1;
    end else begin
      tx_DataValid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed self-checking bench for multicycle_control_fsm. Outputs are
// packed into one vector {alu_src_a, alu_src_b, alu_op, result_src,
// adr_src, ir_write, pc_update, branch, reg_write, mem_write, illegal_op}
// and compared against hand-built expectations after inputs settle,
// between clock edges.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic       mem_ready;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic       adr_src, ir_write, pc_update, branch, reg_write, mem_write, illegal_op;
`ifdef MULTICYCLE_CONTROL_FSM_DEBUG_UART_EN
  logic [7:0] tx_Data;
  logic       tx_DataValid;
`endif

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.OPCODE_W(7)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .mem_ready  (mem_ready),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .result_src (result_src),
    .adr_src    (adr_src),
    .ir_write   (ir_write),
    .pc_update  (pc_update),
    .branch     (branch),
    .reg_write  (reg_write),
    .mem_write  (mem_write),
    .illegal_op (illegal_op)
`ifdef MULTICYCLE_CONTROL_FSM_DEBUG_UART_EN
    ,
    .tx_Data      (tx_Data),
    .tx_DataValid (tx_DataValid)
`endif
  );

  // Expected-vector builder: a, b, aluop, res, adr, irw, pcu, br, rw, mw, ill
  function automatic logic [14:0] mk(input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] ao, input logic [1:0] rs,
                                     input logic adr, input logic irw, input logic pcu,
                                     input logic br, input logic rw, input logic mw,
                                     input logic ill);
    return {a, b, ao, rs, adr, irw, pcu, br, rw, mw, ill};
  endfunction

  localparam logic [14:0] V_ZERO     = 15'h0;
  localparam logic [14:0] V_FETCH    = {2'd0, 2'd2, 2'd0, 2'd2, 1'b0, 1'b1, 1'b1, 4'b0000};
  localparam logic [14:0] V_FETCH_ST = {2'd0, 2'd2, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 4'b0000};

  function automatic logic [14:0] obs();
    return {alu_src_a, alu_src_b, alu_op, result_src, adr_src, ir_write,
            pc_update, branch, reg_write, mem_write, illegal_op};
  endfunction

  task automatic chk(input string tag, input logic [14:0] exp);
    logic [14:0] o;
    #1;
    o = obs();
    nvec++;
    assert (o === exp) else begin
      nerr++;
      $error("FAIL %s observed=%b expected=%b", tag, o, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic [7:0] o, input logic [7:0] exp);
    nvec++;
    assert (o === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, o, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b1; op = 7'b0000011;
    // Reset for 2 cycles: all outputs forced low.
    tick(); chk("reset_c1", V_ZERO);
    tick(); chk("reset_c2", V_ZERO);
    reset = 1'b0;
    chk("post_reset_fetch", V_FETCH);

    // lw: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, then FETCH.
    tick(); chk("lw_decode",  mk(2'd1, 2'd1, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0));
    tick(); chk("lw_memadr",  mk(2'd2, 2'd1, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0));
    tick(); chk("lw_memread", mk(2'd0, 2'd0, 2'd0, 2'd0, 1, 0, 0, 0, 0, 0, 0));
    op = 7'b1111111; // ignored outside DECODE/MEMADR
    tick(); chk("lw_memwb",   mk(2'd0, 2'd0, 2'd0, 2'd1, 0, 0, 0, 0, 1, 0, 0));
    tick(); chk("lw_fetch",   V_FETCH);
`ifdef MULTICYCLE_CONTROL_FSM_DEBUG_UART_EN
    chk_bit("lw_tx_valid", {7'd0, tx_DataValid}, 8'd1);
    chk_bit("lw_tx_data", tx_Data, 8'h04);
`endif

    // Fetch stall: no IR/PC write while memory not ready.
    mem_ready = 1'b0;
    chk("fetch_stall1", V_FETCH_ST);
    tick(); chk("fetch_stall2", V_FETCH_ST);
    mem_ready = 1'b1;
    chk("fetch_resume", V_FETCH);

    // sw with 3 wait cycles in MEMWRITE.
    op = 7'b0100011;
    tick(); chk("sw_decode", mk(2'd1, 2'd1, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0));
    tick(); chk("sw_memadr", mk(2'd2, 2'd1, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0));
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("sw_memwrite_wait", mk(2'd0, 2'd0, 2'd0, 2'd0, 1, 0, 0, 0, 0, 1, 0));
    end
    mem_ready = 1'b1;
    chk("sw_memwrite_done", mk(2'd0, 2'd0, 2'd0, 2'd0, 1, 0, 0, 0, 0, 1, 0));
    tick(); chk("sw_fetch", V_FETCH);

    // R-type.
    op = 7'b0110011;
    tick(); chk("r_decode", mk(2'd1, 2'd1, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0));
    tick(); chk("r_execr",  mk(2'd2, 2'd0, 2'd2, 2'd0, 0, 0, 0, 0, 0, 0, 0));
    tick(); chk("r_aluwb",  mk(2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 1, 0, 0));
    tick(); chk("r_fetch",  V_FETCH);

    // I-type ALU.
    op = 7'b0010011;
    tick(); tick(); chk("i_execi", mk(2'd2, 2'd1, 2'd2, 2'd0, 0, 0, 0, 0, 0, 0, 0));
    tick(); chk("i_aluwb", mk(2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 1, 0, 0));
    tick(); chk("i_fetch", V_FETCH);

    // jal.
    op = 7'b1101111;
    tick(); tick(); chk("jal_jal", mk(2'd1, 2'd2, 2'd0, 2'd0, 0, 0, 1, 0, 0, 0, 0));
    tick(); chk("jal_aluwb", mk(2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 1, 0, 0));
    tick(); chk("jal_fetch", V_FETCH);

    // beq: 3-cycle sequence.
    op = 7'b1100011;
    tick(); tick(); chk("beq_beq", mk(2'd2, 2'd0, 2'd1, 2'd0, 0, 0, 0, 1, 0, 0, 0));
    tick(); chk("beq_fetch", V_FETCH);
`ifdef MULTICYCLE_CONTROL_FSM_DEBUG_UART_EN
    chk_bit("beq_tx_data", tx_Data, 8'h0A);
`endif

    // Illegal opcode.
    op = 7'b1111111;
    tick(); chk("ill_decode", mk(2'd1, 2'd1, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 1));
    tick(); chk("ill_fetch", V_FETCH);

    // Reset in MEMADR abandons the load: FETCH next, not MEMREAD.
    op = 7'b0000011;
    tick(); tick();
    reset = 1'b1;
    chk("rst_memadr", V_ZERO);
    tick(); reset = 1'b0;
    chk("rst_memadr_fetch", V_FETCH);

    // Reset in MEMWB: no reg_write that cycle.
    tick(); tick(); tick(); tick();
    chk("lw2_memwb", mk(2'd0, 2'd0, 2'd0, 2'd1, 0, 0, 0, 0, 1, 0, 0));
    reset = 1'b1;
    chk("rst_memwb", V_ZERO);
    tick(); reset = 1'b0;
    chk("rst_memwb_fetch", V_FETCH);
`ifdef MULTICYCLE_CONTROL_FSM_DEBUG_UART_EN
    chk_bit("rst_no_tx_pulse", {7'd0, tx_DataValid}, 8'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
